// File: rtl/jump_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : jump_ctrl
//  Purpose  : Branch/jump controller for a simple sequencer. Decodes branch
//             operations against a writable jump table, a Z/N flag register
//             and a circular return-address stack, and drives zero-latency
//             jump enables and a jump target to the program counter.
//  Ports    : clk, reset_n           - clock, asynchronous active-low reset
//             prog_ctr               - current program counter
//             br_valid/br_op/br_idx  - branch operation and jump-table index
//             flag_we/flag_z_in/flag_n_in - flag register write port
//             lut_we/lut_waddr/lut_wdata  - jump-table write port
//             reljump_en/absjump_en/target - jump request to the PC
//             ras_err/ras_depth      - sticky stack error, stack occupancy
//  Revision : 1.0 - initial release
// ============================================================================
module jump_ctrl #(
    parameter int D = 10,   // program-counter / target width
    parameter int T = 3,    // jump-table index width
    parameter int S = 4     // return-stack depth
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [D-1:0]         prog_ctr,
    input  logic                 br_valid,
    input  logic [2:0]           br_op,
    input  logic [T-1:0]         br_idx,
    input  logic                 flag_we,
    input  logic                 flag_z_in,
    input  logic                 flag_n_in,
    input  logic                 lut_we,
    input  logic [T-1:0]         lut_waddr,
    input  logic [D-1:0]         lut_wdata,
    output logic                 reljump_en,
    output logic                 absjump_en,
    output logic [D-1:0]         target,
    output logic                 ras_err,
    output logic [$clog2(S):0]   ras_depth
);

    localparam int c_PTR_W   = (S > 1) ? $clog2(S) : 1;
    localparam int c_DEPTH_W = $clog2(S) + 1;
    localparam int c_LUT_N   = 2 ** T;

    localparam logic [2:0] c_OP_JABS = 3'd1;
    localparam logic [2:0] c_OP_JREL = 3'd2;
    localparam logic [2:0] c_OP_BEQZ = 3'd3;
    localparam logic [2:0] c_OP_BLTZ = 3'd4;
    localparam logic [2:0] c_OP_CALL = 3'd5;
    localparam logic [2:0] c_OP_RET  = 3'd6;

    localparam logic [c_DEPTH_W-1:0] c_DEPTH_MAX = c_DEPTH_W'(S);
    localparam logic [c_PTR_W-1:0]   c_PTR_LAST  = c_PTR_W'(S - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [D-1:0]          r_lut   [c_LUT_N];
    logic [D-1:0]          r_stack [S];
    logic [c_PTR_W-1:0]    r_sp;        // next free slot (circular)
    logic [c_DEPTH_W-1:0]  r_depth;
    logic                  r_err;
    logic                  r_z;
    logic                  r_n;

    // Circular pointer helpers; S need not be a power of two.
    function automatic logic [c_PTR_W-1:0] ptr_inc(input logic [c_PTR_W-1:0] p);
        return (p == c_PTR_LAST) ? '0 : p + c_PTR_W'(1);
    endfunction

    function automatic logic [c_PTR_W-1:0] ptr_dec(input logic [c_PTR_W-1:0] p);
        return (p == '0) ? c_PTR_LAST : p - c_PTR_W'(1);
    endfunction

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    logic [D-1:0]  w_lut_rd;
    logic [D-1:0]  w_top;
    logic [D-1:0]  w_ret_addr;
    logic          w_rel;
    logic          w_abs;
    logic [D-1:0]  w_tgt;
    logic          w_push;
    logic          w_pop;
    logic          w_underflow;

    assign w_lut_rd   = r_lut[br_idx];
    assign w_top      = r_stack[ptr_dec(r_sp)];
    assign w_ret_addr = prog_ctr + D'(1);

    always_comb begin
        w_rel       = 1'b0;
        w_abs       = 1'b0;
        w_tgt       = '0;
        w_push      = 1'b0;
        w_pop       = 1'b0;
        w_underflow = 1'b0;
        if (br_valid) begin
            case (br_op)
                c_OP_JABS: begin
                    w_abs = 1'b1;
                    w_tgt = w_lut_rd;
                end
                c_OP_JREL: begin
                    w_rel = 1'b1;
                    w_tgt = w_lut_rd;
                end
                // Conditional branches see only the registered flags, so a
                // same-cycle flag write cannot influence the decision.
                c_OP_BEQZ: begin
                    if (r_z) begin
                        w_rel = 1'b1;
                        w_tgt = w_lut_rd;
                    end
                end
                c_OP_BLTZ: begin
                    if (r_n) begin
                        w_rel = 1'b1;
                        w_tgt = w_lut_rd;
                    end
                end
                c_OP_CALL: begin
                    w_abs  = 1'b1;
                    w_tgt  = w_lut_rd;
                    w_push = 1'b1;
                end
                c_OP_RET: begin
                    if (r_depth != '0) begin
                        w_abs = 1'b1;
                        w_tgt = w_top;
                        w_pop = 1'b1;
                    end else begin
                        w_underflow = 1'b1;
                    end
                end
                default: ;  // NOP and reserved
            endcase
        end
    end

    // Reset forces the jump request quiet even though table entries read 0.
    assign reljump_en = reset_n & w_rel;
    assign absjump_en = reset_n & w_abs;
    assign target     = reset_n ? w_tgt : '0;
    assign ras_err    = r_err;
    assign ras_depth  = r_depth;

    // ------------------------------------------------------------------
    // Jump table and flags
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < c_LUT_N; i++) begin
                r_lut[i] <= '0;
            end
            r_z <= 1'b0;
            r_n <= 1'b0;
        end else begin
            if (lut_we) begin
                r_lut[lut_waddr] <= lut_wdata;
            end
            if (flag_we) begin
                r_z <= flag_z_in;
                r_n <= flag_n_in;
            end
        end
    end

    // ------------------------------------------------------------------
    // Return stack. When full, the next free slot coincides with the
    // oldest entry, so a push simply overwrites it.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < S; i++) begin
                r_stack[i] <= '0;
            end
            r_sp    <= '0;
            r_depth <= '0;
            r_err   <= 1'b0;
        end else begin
            if (w_push) begin
                r_stack[r_sp] <= w_ret_addr;
                r_sp          <= ptr_inc(r_sp);
                if (r_depth == c_DEPTH_MAX) begin
                    r_err <= 1'b1;
                end else begin
                    r_depth <= r_depth + c_DEPTH_W'(1);
                end
            end else if (w_pop) begin
                r_sp    <= ptr_dec(r_sp);
                r_depth <= r_depth - c_DEPTH_W'(1);
            end else if (w_underflow) begin
                r_err <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_jump_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_jump_ctrl
//  Purpose  : Directed self-checking bench for jump_ctrl (D=10, T=3, S=4).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_jump_ctrl;

    localparam int D = 10;
    localparam int T = 3;
    localparam int S = 4;

    localparam logic [2:0] NOP  = 3'd0;
    localparam logic [2:0] JABS = 3'd1;
    localparam logic [2:0] JREL = 3'd2;
    localparam logic [2:0] BEQZ = 3'd3;
    localparam logic [2:0] BLTZ = 3'd4;
    localparam logic [2:0] CALL = 3'd5;
    localparam logic [2:0] RET  = 3'd6;
    localparam logic [2:0] RSVD = 3'd7;

    logic               clk;
    logic               reset_n;
    logic [D-1:0]       prog_ctr;
    logic               br_valid;
    logic [2:0]         br_op;
    logic [T-1:0]       br_idx;
    logic               flag_we;
    logic               flag_z_in;
    logic               flag_n_in;
    logic               lut_we;
    logic [T-1:0]       lut_waddr;
    logic [D-1:0]       lut_wdata;
    logic               reljump_en;
    logic               absjump_en;
    logic [D-1:0]       target;
    logic               ras_err;
    logic [$clog2(S):0] ras_depth;

    int checks = 0;
    int errors = 0;

    jump_ctrl #(.D(D), .T(T), .S(S)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .prog_ctr   (prog_ctr),
        .br_valid   (br_valid),
        .br_op      (br_op),
        .br_idx     (br_idx),
        .flag_we    (flag_we),
        .flag_z_in  (flag_z_in),
        .flag_n_in  (flag_n_in),
        .lut_we     (lut_we),
        .lut_waddr  (lut_waddr),
        .lut_wdata  (lut_wdata),
        .reljump_en (reljump_en),
        .absjump_en (absjump_en),
        .target     (target),
        .ras_err    (ras_err),
        .ras_depth  (ras_depth)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_jump(input string tag, input logic rel, input logic abs,
                            input logic [D-1:0] tgt);
        chk({tag, ".rel"}, 32'(reljump_en), 32'(rel));
        chk({tag, ".abs"}, 32'(absjump_en), 32'(abs));
        chk({tag, ".tgt"}, 32'(target),     32'(tgt));
    endtask

    // Apply a new input vector on the falling edge (all write ports idle).
    task automatic drive(input logic v, input logic [2:0] op, input logic [T-1:0] idx,
                         input logic [D-1:0] pc);
        @(negedge clk);
        br_valid  = v;
        br_op     = op;
        br_idx    = idx;
        prog_ctr  = pc;
        flag_we   = 1'b0;
        flag_z_in = 1'b0;
        flag_n_in = 1'b0;
        lut_we    = 1'b0;
        lut_waddr = '0;
        lut_wdata = '0;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n   = 1'b0;
        prog_ctr  = '0;
        br_valid  = 1'b1;
        br_op     = JABS;
        br_idx    = '0;
        flag_we   = 1'b0;
        flag_z_in = 1'b0;
        flag_n_in = 1'b0;
        lut_we    = 1'b0;
        lut_waddr = '0;
        lut_wdata = '0;

        // Reset state: outputs quiet even with a JABS presented.
        repeat (2) @(posedge clk);
        #1;
        chk_jump("rst", 1'b0, 1'b0, 10'h000);
        chk("rst.depth", 32'(ras_depth), 32'd0);
        chk("rst.err",   32'(ras_err),   32'd0);

        // RET on empty stack right after reset.
        drive(1'b0, NOP, 3'd0, 10'h000);
        reset_n = 1'b1;
        drive(1'b1, RET, 3'd0, 10'h000);
        chk_jump("ret_empty", 1'b0, 1'b0, 10'h000);
        tick();
        chk("ret_empty.err",   32'(ras_err),   32'd1);
        chk("ret_empty.depth", 32'(ras_depth), 32'd0);

        // Asynchronous reset mid-CALL: immediate clear, push discarded.
        drive(1'b1, CALL, 3'd0, 10'h007);
        chk_jump("call0", 1'b0, 1'b1, 10'h000);
        reset_n = 1'b0;
        #1;
        chk("arst.err", 32'(ras_err), 32'd0);
        chk_jump("arst", 1'b0, 1'b0, 10'h000);
        tick();
        chk("arst.depth", 32'(ras_depth), 32'd0);
        drive(1'b0, NOP, 3'd0, 10'h000);
        reset_n = 1'b1;

        // Table write with same-cycle read returns the old value.
        drive(1'b1, JABS, 3'd3, 10'h000);
        lut_we = 1'b1; lut_waddr = 3'd3; lut_wdata = 10'h055;
        #1;
        chk_jump("lut_old", 1'b0, 1'b1, 10'h000);
        tick();
        drive(1'b1, JABS, 3'd3, 10'h000);
        chk_jump("lut_new", 1'b0, 1'b1, 10'h055);

        // JREL with a negative offset.
        drive(1'b0, JABS, 3'd2, 10'h000);
        lut_we = 1'b1; lut_waddr = 3'd2; lut_wdata = 10'h3F0;
        #1;
        chk_jump("nvalid", 1'b0, 1'b0, 10'h000);
        tick();
        drive(1'b1, JREL, 3'd2, 10'h000);
        chk_jump("jrel", 1'b1, 1'b0, 10'h3F0);

        // CALL then RET.
        drive(1'b0, NOP, 3'd0, 10'h005);
        lut_we = 1'b1; lut_waddr = 3'd1; lut_wdata = 10'h120;
        tick();
        drive(1'b1, CALL, 3'd1, 10'h005);
        chk_jump("call", 1'b0, 1'b1, 10'h120);
        tick();
        chk("call.depth", 32'(ras_depth), 32'd1);
        drive(1'b1, RET, 3'd0, 10'h130);
        chk_jump("ret", 1'b0, 1'b1, 10'h006);
        tick();
        chk("ret.depth", 32'(ras_depth), 32'd0);
        chk("ret.err",   32'(ras_err),   32'd0);

        // Flags: same-cycle write does not affect the branch.
        drive(1'b1, BEQZ, 3'd2, 10'h000);
        flag_we = 1'b1; flag_z_in = 1'b1; flag_n_in = 1'b0;
        #1;
        chk_jump("beqz_same", 1'b0, 1'b0, 10'h000);
        tick();
        drive(1'b1, BEQZ, 3'd2, 10'h000);
        chk_jump("beqz_next", 1'b1, 1'b0, 10'h3F0);
        drive(1'b1, BLTZ, 3'd3, 10'h000);
        chk_jump("bltz_nt", 1'b0, 1'b0, 10'h000);
        flag_we = 1'b1; flag_z_in = 1'b0; flag_n_in = 1'b1;
        tick();
        drive(1'b1, BLTZ, 3'd3, 10'h000);
        chk_jump("bltz_t", 1'b1, 1'b0, 10'h055);
        drive(1'b1, BEQZ, 3'd3, 10'h000);
        chk_jump("beqz_nt", 1'b0, 1'b0, 10'h000);

        // NOP and reserved opcodes.
        drive(1'b1, NOP, 3'd3, 10'h000);
        chk_jump("nop", 1'b0, 1'b0, 10'h000);
        drive(1'b1, RSVD, 3'd3, 10'h000);
        chk_jump("rsvd", 1'b0, 1'b0, 10'h000);

        // Overflow: five CALLs into a four-deep stack.
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, CALL, 3'd1, 10'(10'h010 + i));
            chk_jump("ovf_call", 1'b0, 1'b1, 10'h120);
            tick();
            if (i == 3) begin
                chk("full.depth", 32'(ras_depth), 32'd4);
                chk("full.err",   32'(ras_err),   32'd0);
            end
        end
        chk("ovf.depth", 32'(ras_depth), 32'd4);
        chk("ovf.err",   32'(ras_err),   32'd1);
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, RET, 3'd0, 10'h200);
            chk_jump("ovf_ret", 1'b0, 1'b1, 10'(10'h015 - i));
            tick();
            chk("ovf_ret.depth", 32'(ras_depth), 32'(3 - i));
        end
        drive(1'b1, RET, 3'd0, 10'h200);
        chk_jump("unf_ret", 1'b0, 1'b0, 10'h000);
        tick();
        chk("unf.err",   32'(ras_err),   32'd1);
        chk("unf.depth", 32'(ras_depth), 32'd0);

        drive(1'b0, NOP, 3'd0, 10'h000);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
